uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_fifo_if.sv | 40 ++++
 rtl/uart_rx_fifo_mem.sv | 37 +++
 rtl/uart_rx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART receive-path constants, FIFO operation encoding and
//          the depth-to-occupancy-width helper.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PKT_LEN_W      = 10;

    // Bit 1 = read accepted, bit 0 = write accepted.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_BOTH  = 2'd3
    } fifo_op_e;

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_fifo_if
// Brief  : Producer/consumer bundle for the UART receive FIFO.
// Rev    : 1.0
// ============================================================================
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    localparam int CNT_W = count_width(DEPTH);

    logic                  rx_data_valid;
    logic [DATA_WIDTH-1:0] rx_data_byte;
    logic [PKT_LEN_W-1:0]  bytes_to_rx;
    logic                  clear;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  full;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  packet_done;

    modport master (
        output rx_data_valid, rx_data_byte, bytes_to_rx, clear, rd_en,
        input  rd_data, rd_valid, empty, full, count, overflow, packet_done
    );

    modport slave (
        input  rx_data_valid, rx_data_byte, bytes_to_rx, clear, rd_en,
        output rd_data, rd_valid, empty, full, count, overflow, packet_done
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_fifo_mem
// Brief  : DEPTH x DATA_WIDTH storage, one write port, one registered
//          read-first read port, no reset.
// Rev    : 1.0
// ============================================================================
module uart_rx_fifo_mem #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clock_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]    rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Same-address read and write (full FIFO) returns the old entry.
    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_fifo
// Brief  : Byte FIFO behind a UART receiver with overflow flag and
//          packet-length tracking.
// Rev    : 1.0
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic         clock_i,
    input  logic         reset_i,
    uart_rx_fifo_if.slave fifo_if
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic [PKT_LEN_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic                  packet_done_q, packet_done_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_seen_q, rd_seen_d;

    logic                  rd_accept;
    logic                  wr_accept;
    fifo_op_e              op;
    logic [PKT_LEN_W-1:0]  pkt_next;
    logic [DATA_WIDTH-1:0] mem_rdata;

    uart_rx_fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clock_i   (clock_i),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (fifo_if.rx_data_byte),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (mem_rdata)
    );

    always_comb begin
        rd_accept = fifo_if.rd_en && !empty_q && !fifo_if.clear;
        wr_accept = fifo_if.rx_data_valid && (!full_q || rd_accept) && !fifo_if.clear;
        op        = fifo_op_e'({rd_accept, wr_accept});
        pkt_next  = pkt_cnt_q + PKT_LEN_W'(1);

        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        pkt_cnt_d     = pkt_cnt_q;
        packet_done_d = 1'b0;
        rd_valid_d    = rd_accept;
        rd_seen_d     = rd_seen_q | rd_accept;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case (op)
            OP_WRITE: count_d = count_q + CNT_W'(1);
            OP_READ:  count_d = count_q - CNT_W'(1);
            default:  count_d = count_q;
        endcase

        if (fifo_if.rx_data_valid && !wr_accept) begin
            overflow_d = 1'b1;
        end

        // A length lowered below the running count restarts the packet silently.
        if (fifo_if.bytes_to_rx == '0) begin
            pkt_cnt_d = '0;
        end else if (wr_accept) begin
            if (pkt_next == fifo_if.bytes_to_rx) begin
                pkt_cnt_d     = '0;
                packet_done_d = 1'b1;
            end else if (pkt_next > fifo_if.bytes_to_rx) begin
                pkt_cnt_d = '0;
            end else begin
                pkt_cnt_d = pkt_next;
            end
        end

        if (fifo_if.clear) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            overflow_d    = 1'b0;
            pkt_cnt_d     = '0;
            packet_done_d = 1'b0;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            overflow_q    <= 1'b0;
            pkt_cnt_q     <= '0;
            packet_done_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_seen_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            overflow_q    <= overflow_d;
            pkt_cnt_q     <= pkt_cnt_d;
            packet_done_q <= packet_done_d;
            rd_valid_q    <= rd_valid_d;
            rd_seen_q     <= rd_seen_d;
        end
    end

    // Storage has no reset, so rd_data is masked to zero until the first pop.
    assign fifo_if.rd_data     = rd_seen_q ? mem_rdata : '0;
    assign fifo_if.rd_valid    = rd_valid_q;
    assign fifo_if.empty       = empty_q;
    assign fifo_if.full        = full_q;
    assign fifo_if.count       = count_q;
    assign fifo_if.overflow    = overflow_q;
    assign fifo_if.packet_done = packet_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_fifo
// Brief  : Directed and randomized checks of uart_rx_fifo against a queue model.
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic clk;
    logic rst;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .fifo_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] m_q[$];
    bit            m_ovf;
    int            m_pk;
    bit            m_done;
    bit            m_valid;
    logic [DW-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_pk    = 0;
        m_done  = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    task automatic check_all();
        chk("count",       32'(bus.count),       32'(m_q.size()));
        chk("empty",       32'(bus.empty),       32'(m_q.size() == 0));
        chk("full",        32'(bus.full),        32'(m_q.size() == DEPTH));
        chk("overflow",    32'(bus.overflow),    32'(m_ovf));
        chk("rd_valid",    32'(bus.rd_valid),    32'(m_valid));
        chk("rd_data",     32'(bus.rd_data),     32'(m_data));
        chk("packet_done", 32'(bus.packet_done), 32'(m_done));
    endtask

    // One clock: drive, let the DUT take the edge, advance the model, compare.
    task automatic step(input bit vld, input logic [DW-1:0] b, input bit rd, input bit clr);
        bit ra, wa;
        int btr;
        bus.rx_data_valid = vld;
        bus.rx_data_byte  = b;
        bus.rd_en         = rd;
        bus.clear         = clr;
        @(posedge clk);
        btr = int'(bus.bytes_to_rx);
        ra  = rd && (m_q.size() > 0) && !clr;
        wa  = vld && ((m_q.size() < DEPTH) || ra) && !clr;
        m_done  = 1'b0;
        m_valid = 1'b0;
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_pk  = 0;
        end else begin
            if (ra) begin
                m_data  = m_q.pop_front();
                m_valid = 1'b1;
            end
            if (wa) m_q.push_back(b);
            if (vld && !wa) m_ovf = 1'b1;
            if (btr == 0) begin
                m_pk = 0;
            end else if (wa) begin
                m_pk++;
                if (m_pk == btr) begin
                    m_done = 1'b1;
                    m_pk   = 0;
                end else if (m_pk > btr) begin
                    m_pk = 0;
                end
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [DW-1:0] seq4 [4];
        bit            vld, rd, clr;
        int            pv, pr;

        seq4 = '{8'h77, 8'hC9, 8'hEB, 8'h4D};
        bus.rx_data_valid = 1'b0;
        bus.rx_data_byte  = '0;
        bus.bytes_to_rx   = '0;
        bus.clear         = 1'b0;
        bus.rd_en         = 1'b0;
        rst = 1'b0;
        m_reset();

        #1 rst = 1'b1;
        #1;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Packet tracking with four writes and bytes_to_rx = 3.
        bus.bytes_to_rx = 10'd3;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq4[i], 1'b0, 1'b0);
            if (i == 2) chk("pkt_done_after_EB", 32'(bus.packet_done), 32'd1);
        end
        chk("count_after_4", 32'(bus.count), 32'd4);
        chk("pkt_done_cleared", 32'(bus.packet_done), 32'd0);

        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("rd_seq_data", 32'(bus.rd_data), 32'(seq4[i]));
            chk("rd_seq_valid", 32'(bus.rd_valid), 32'd1);
        end
        chk("empty_after_drain", 32'(bus.empty), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Fill past capacity.
        bus.bytes_to_rx = '0;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
            if (i == 15) chk("full_at_16", 32'(bus.full), 32'd1);
        end
        chk("ovf_after_17", 32'(bus.overflow), 32'd1);
        chk("count_after_17", 32'(bus.count), 32'd16);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("first_byte_kept", 32'(bus.rd_data), 32'h10);
        step(1'b1, 8'h99, 1'b0, 1'b0);

        // Clear removes sticky overflow.
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);
        chk("rd_valid_on_clear", 32'(bus.rd_valid), 32'd0);

        // Full FIFO with simultaneous read and write.
        for (int i = 0; i < 16; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("full_rw_count", 32'(bus.count), 32'd16);
        chk("full_rw_ovf", 32'(bus.overflow), 32'd0);
        chk("full_rw_data", 32'(bus.rd_data), 32'h40);
        step(1'b0, '0, 1'b0, 1'b1);

        // Empty FIFO: no fall-through.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("empty_rw_valid", 32'(bus.rd_valid), 32'd0);
        chk("empty_rw_count", 32'(bus.count), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("a5_readback", 32'(bus.rd_data), 32'hA5);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 6; i++) step(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("pre_reset_count", 32'(bus.count), 32'd5);
        rst = 1'b1;
        #2;
        m_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("first_write_after_reset", 32'(bus.count), 32'd1);

        // Randomized traffic with alternating fill/drain bias.
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) bus.bytes_to_rx = 10'($urandom_range(0, 6));
            pv  = ((i / 200) % 2 == 0) ? 80 : 30;
            pr  = ((i / 200) % 2 == 0) ? 30 : 80;
            vld = ($urandom_range(0, 99) < pv);
            rd  = ($urandom_range(0, 99) < pr);
            clr = ($urandom_range(0, 199) == 0);
            step(vld, DW'($urandom), rd, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
